fp_mult_pipe: RTL and testbench
===============================

// Module: fp_mult_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754-style floating-point multiplier; the successor to the fixed fp16 multiplier.
//  Configurable exponent/mantissa widths, selectable rounding, full special-case handling and exception flags.
//  Valid/ready handshake on both sides so the block can sit inside the vertex-transform datapath under backpressure.
// PARAMETERS
//  EXP_W   5   exponent field width; bias = 2**(EXP_W-1)-1
//  MAN_W   10  stored mantissa field width (hidden bit implied); W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous reset, active-high
//  in_valid   in   1   operands a,b,rnd_mode valid this cycle
//  in_ready   out  1   block accepts operands this cycle
//  a          in   W   operand A
//  b          in   W   operand B
//  rnd_mode   in   1   0 = round-to-nearest-even, 1 = round-toward-zero
//  out_valid  out  1   x and flags valid
//  out_ready  in   1   downstream accepts x this cycle
//  x          out  W   product
//  flags      out  4   {invalid, overflow, underflow, inexact}
// BEHAVIOUR
//  Reset: all stage valids=0, out_valid=0, x=0, flags=0; async assert, sync-safe release. Mid-operation reset drops all in-flight ops.
//  Pipeline: 3 stages, latency 3 cycles from accepted input to out_valid when unstalled; throughput 1/cycle.
//   S1: unpack, classify (zero/sub/norm/inf/nan), sign = sa^sb, exp sum ea+eb-bias in EXP_W+2-bit signed,
//       mantissa product (MAN_W+1)x(MAN_W+1) -> 2*MAN_W+2 bits.
//   S2: normalise (product MSB set -> shift right 1, exp+1), form guard/round/sticky.
//   S3: round, renormalise on mantissa carry-out, over/underflow check, specials mux, register x/flags.
//  Handshake: adv = ~out_valid | out_ready; in_ready = adv; all stages shift only when adv. Transfer in: in_valid&in_ready;
//   transfer out: out_valid&out_ready. Stall holds x/flags/out_valid stable. Bubbles are not collapsed.
//  Subnormals: subnormal inputs treated as signed zero (flush-to-zero); subnormal-range results -> signed zero, underflow=1, inexact=1.
//  Specials (priority order): any NaN -> canonical qNaN {0,all-ones exp,1,0..0}; inf*zero -> qNaN, invalid=1;
//   inf*finite -> signed inf; zero*finite -> signed zero. No other flags for specials.
//  Overflow (rounded exp >= 2**EXP_W-1): RNE -> signed inf; RTZ -> signed max finite; overflow=1, inexact=1.
//  RNE: round up iff G&(R|S|LSB). RTZ: truncate. inexact = G|R|S for finite normal results.
//  Mantissa round carry-out increments exponent and may itself trigger overflow.
//  flags are sticky per result only (not accumulated); valid only with out_valid.
// TESTING (default EXP_W=5, MAN_W=10)
//  1: a=3C00(1.0) b=4000(2.0) RNE -> x=4000, flags=0, out_valid 3 cycles after accept.
//  2: a=4200(3.0) b=4500(5.0) -> 4B80(15.0); a=C000 b=4000 -> C400; flags=0.
//  3: a=3C01 b=3C01 RNE -> 3C02 inexact=1; same in RTZ -> 3C02 (exact bits 1+2^-9+2^-20 truncated) inexact=1.
//  4: a=7BFF b=4000: RNE -> 7C00, RTZ -> 7BFF, overflow=1 inexact=1; a=7C00 b=0000 -> 7E00 invalid=1;
//     a=7E00 b=3C00 -> 7E00 flags=0; a=0400 b=3800 -> 0000 underflow=1.
//  5: back-to-back 8 ops with out_ready low for 4 cycles mid-stream -> in_ready low while stalled,
//     all 8 results emerge in order, none dropped/duplicated, x stable during stall.
//  6: assert rst with 3 ops in flight -> out_valid=0, x=0 immediately; first op after release appears 3 cycles later.

Source files
------------

// File: rtl/fp_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mult_pipe
//  Description : Parametrised 3-stage pipelined floating-point multiplier with
//                RNE/RTZ rounding, flush-to-zero subnormals, special-value
//                handling, exception flags and valid/ready flow control.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mult_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x,
  output logic [3:0]   flags
);

  // Internal exponent width leaves room for carry and negative (underflow) values.
  localparam int EW = EXP_W + 2;
  // Raw mantissa product width.
  localparam int PW = 2 * MAN_W + 2;

  localparam logic [EW-1:0]    BIAS_E    = EW'(2**(EXP_W-1) - 1);
  localparam logic [EW-1:0]    EXP_MAX_E = EW'(2**EXP_W - 1);
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [W-1:0]     QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Reset: asserted asynchronously, released through two flops so every
  // pipeline register leaves reset on the same clean edge.
  logic rst_meta;
  logic rst_sync;

  // Reset synchroniser: async set, synchronous deassert.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  // Whole pipeline advances together; bubbles are carried, not collapsed.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~rst_sync;

  // ---------------------------------------------------------------- stage 1
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             sign_w;
  logic [EW-1:0]    exp_sum;
  logic [PW-1:0]    prod;
  logic             sp_w;
  logic [W-1:0]     sp_x_w;
  logic             sp_inv_w;

  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];

  // Zero exponent covers both true zero and flushed subnormals.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);

  assign sign_w  = sa ^ sb;
  assign exp_sum = EW'(ea) + EW'(eb) - BIAS_E;
  assign prod    = PW'({1'b1, ma}) * PW'({1'b1, mb});

  // Special-operand result selection in priority order.
  always_comb begin
    sp_w     = 1'b0;
    sp_x_w   = '0;
    sp_inv_w = 1'b0;
    if (a_nan || b_nan) begin
      sp_w   = 1'b1;
      sp_x_w = QNAN;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      sp_w     = 1'b1;
      sp_x_w   = QNAN;
      sp_inv_w = 1'b1;
    end else if (a_inf || b_inf) begin
      sp_w   = 1'b1;
      sp_x_w = {sign_w, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      sp_w   = 1'b1;
      sp_x_w = {sign_w, {(W-1){1'b0}}};
    end
  end

  logic          s1_valid, s1_rnd, s1_sign, s1_sp, s1_sp_inv;
  logic [EW-1:0] s1_exp;
  logic [PW-1:0] s1_prod;
  logic [W-1:0]  s1_sp_x;

  // Stage 1 register: unpacked operands, exponent sum and raw product.
  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      s1_valid  <= 1'b0;
      s1_rnd    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sp     <= 1'b0;
      s1_sp_inv <= 1'b0;
      s1_exp    <= '0;
      s1_prod   <= '0;
      s1_sp_x   <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_rnd    <= rnd_mode;
      s1_sign   <= sign_w;
      s1_sp     <= sp_w;
      s1_sp_inv <= sp_inv_w;
      s1_exp    <= exp_sum;
      s1_prod   <= prod;
      s1_sp_x   <= sp_x_w;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [MAN_W:0] n_man;
  logic [EW-1:0]  n_exp;
  logic           n_g, n_r, n_s;

  // Product lies in [1,4): a set MSB means shift right by one and bump exponent.
  always_comb begin
    if (s1_prod[PW-1]) begin
      n_man = s1_prod[PW-1 -: MAN_W+1];
      n_g   = s1_prod[PW-MAN_W-2];
      n_r   = s1_prod[PW-MAN_W-3];
      n_s   = |s1_prod[PW-MAN_W-4:0];
      n_exp = s1_exp + EW'(1);
    end else begin
      n_man = s1_prod[PW-2 -: MAN_W+1];
      n_g   = s1_prod[PW-MAN_W-3];
      n_r   = s1_prod[PW-MAN_W-4];
      n_s   = |s1_prod[PW-MAN_W-5:0];
      n_exp = s1_exp;
    end
  end

  logic           s2_valid, s2_rnd, s2_sign, s2_sp, s2_sp_inv;
  logic           s2_g, s2_r, s2_s;
  logic [EW-1:0]  s2_exp;
  logic [MAN_W:0] s2_man;
  logic [W-1:0]   s2_sp_x;

  // Stage 2 register: normalised mantissa with guard/round/sticky.
  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      s2_valid  <= 1'b0;
      s2_rnd    <= 1'b0;
      s2_sign   <= 1'b0;
      s2_sp     <= 1'b0;
      s2_sp_inv <= 1'b0;
      s2_g      <= 1'b0;
      s2_r      <= 1'b0;
      s2_s      <= 1'b0;
      s2_exp    <= '0;
      s2_man    <= '0;
      s2_sp_x   <= '0;
    end else if (adv) begin
      s2_valid  <= s1_valid;
      s2_rnd    <= s1_rnd;
      s2_sign   <= s1_sign;
      s2_sp     <= s1_sp;
      s2_sp_inv <= s1_sp_inv;
      s2_g      <= n_g;
      s2_r      <= n_r;
      s2_s      <= n_s;
      s2_exp    <= n_exp;
      s2_man    <= n_man;
      s2_sp_x   <= s1_sp_x;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic             round_up;
  logic [MAN_W+1:0] rounded;
  logic [EW-1:0]    r_exp;
  logic [MAN_W-1:0] r_frac;
  logic             inexact, ovf, unf;
  logic [W-1:0]     res_x;
  logic [3:0]       res_flags;

  assign round_up = ~s2_rnd & s2_g & (s2_r | s2_s | s2_man[0]);
  assign rounded  = {1'b0, s2_man} + (MAN_W+2)'(round_up);
  assign inexact  = s2_g | s2_r | s2_s;

  // Mantissa carry-out renormalises and may push the exponent into overflow.
  always_comb begin
    if (rounded[MAN_W+1]) begin
      r_exp  = s2_exp + EW'(1);
      r_frac = rounded[MAN_W:1];
    end else begin
      r_exp  = s2_exp;
      r_frac = rounded[MAN_W-1:0];
    end
  end

  assign ovf = ~r_exp[EW-1] && (r_exp >= EXP_MAX_E);
  assign unf = r_exp[EW-1] || (r_exp == '0);

  // Final result mux: specials, overflow, underflow, then normal.
  always_comb begin
    res_x     = {s2_sign, r_exp[EXP_W-1:0], r_frac};
    res_flags = {3'b000, inexact};
    if (s2_sp) begin
      res_x     = s2_sp_x;
      res_flags = {s2_sp_inv, 3'b000};
    end else if (ovf) begin
      if (s2_rnd)
        res_x = {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else
        res_x = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      res_flags = 4'b0101;
    end else if (unf) begin
      res_x     = {s2_sign, {(W-1){1'b0}}};
      res_flags = 4'b0011;
    end
  end

  // Output register: holds x/flags/out_valid steady while downstream stalls.
  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      out_valid <= 1'b0;
      x         <= '0;
      flags     <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        x     <= res_x;
        flags <= res_flags;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fp_mult_pipe
//  Description : Directed self-checking bench for fp_mult_pipe (fp16 layout).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        rnd_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] x;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  // 100 MHz clock.
  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .flags     (flags)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        rnd;
    logic [15:0] ex;
    logic [3:0]  ef;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation from posedge+1, wait for the result and compare.
  task automatic run_vec(input int idx);
    int cyc;
    a        = vecs[idx].a;
    b        = vecs[idx].b;
    rnd_mode = vecs[idx].rnd;
    in_valid = 1'b1;
    check($sformatf("in_ready[%0d]", idx), 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("latency[%0d]", idx), 32'(cyc), 32'd3);
    check($sformatf("x[%0d]", idx), 32'(x), 32'(vecs[idx].ex));
    check($sformatf("flags[%0d]", idx), 32'(flags), 32'(vecs[idx].ef));
  endtask

  initial begin
    logic [15:0] bs [8];
    logic [15:0] held;
    logic        prev_stall;
    logic        fire_in;
    logic        fire_out;
    int          tx;
    int          rx;

    //               a         b         rnd   x         flags{inv,ovf,unf,inx}
    vecs[0]  = '{16'h3C00, 16'h4000, 1'b0, 16'h4000, 4'b0000};
    vecs[1]  = '{16'h4200, 16'h4500, 1'b0, 16'h4B80, 4'b0000};
    vecs[2]  = '{16'hC000, 16'h4000, 1'b0, 16'hC400, 4'b0000};
    vecs[3]  = '{16'h3C01, 16'h3C01, 1'b0, 16'h3C02, 4'b0001};
    vecs[4]  = '{16'h3C01, 16'h3C01, 1'b1, 16'h3C02, 4'b0001};
    vecs[5]  = '{16'h7BFF, 16'h4000, 1'b0, 16'h7C00, 4'b0101};
    vecs[6]  = '{16'h7BFF, 16'h4000, 1'b1, 16'h7BFF, 4'b0101};
    vecs[7]  = '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'b1000};
    vecs[8]  = '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000};
    vecs[9]  = '{16'h0400, 16'h3800, 1'b0, 16'h0000, 4'b0011};
    vecs[10] = '{16'hFC00, 16'h4000, 1'b0, 16'hFC00, 4'b0000};
    vecs[11] = '{16'h8000, 16'h4000, 1'b0, 16'h8000, 4'b0000};
    vecs[12] = '{16'h0001, 16'h3C00, 1'b0, 16'h0000, 4'b0000};
    vecs[13] = '{16'h3C01, 16'h3E00, 1'b0, 16'h3E02, 4'b0001};
    vecs[14] = '{16'h3C01, 16'h3E00, 1'b1, 16'h3E01, 4'b0001};
    vecs[15] = '{16'h3C03, 16'h3E00, 1'b0, 16'h3E04, 4'b0001};
    vecs[16] = '{16'h3BFE, 16'h3C01, 1'b0, 16'h3C00, 4'b0001};
    vecs[17] = '{16'h3BFE, 16'h3C01, 1'b1, 16'h3BFF, 4'b0001};
    vecs[18] = '{16'h7BFE, 16'h3C01, 1'b0, 16'h7C00, 4'b0101};
    vecs[19] = '{16'h7BFE, 16'h3C01, 1'b1, 16'h7BFF, 4'b0001};

    bs = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};

    // Reset state.
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Directed vector table.
    for (int i = 0; i < NV; i++) run_vec(i);
    @(posedge clk); #1;

    // Streaming with a 4-cycle downstream stall mid-stream.
    rnd_mode   = 1'b0;
    a          = 16'h4000;
    b          = bs[0];
    in_valid   = 1'b1;
    tx         = 0;
    rx         = 0;
    held       = '0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 8);
      @(negedge clk);
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (out_valid && !out_ready) begin
        check($sformatf("stall_in_ready[%0d]", cyc), 32'(in_ready), 32'd0);
        if (prev_stall) check($sformatf("stall_x_stable[%0d]", cyc), 32'(x), 32'(held));
        held       = x;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (fire_out) begin
        check($sformatf("stream_x[%0d]", rx), 32'(x), 32'(bs[rx] + 16'h0400));
        check($sformatf("stream_flags[%0d]", rx), 32'(flags), 32'd0);
        rx++;
      end
      @(posedge clk); #1;
      if (fire_in) begin
        tx++;
        if (tx < 8) b = bs[tx];
        else in_valid = 1'b0;
      end
    end
    check("stream_count", 32'(rx), 32'd8);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stream_no_dup[%0d]", i), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Reset with three operations in flight.
    a        = 16'h4000;
    b        = 16'h4200;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("inflight_valid_pre", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_x", 32'(x), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_rst_idle[%0d]", i), 32'(out_valid), 32'd0);
    end
    run_vec(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
